// File: rtl/microcode_sequencer.sv
// microcode_sequencer: SAP-1 style control sequencer with a one-hot T-state
// ring. It adds jumps, a sticky halt, single-step and optional
// variable-length instructions. The ring and the halt flag advance on the
// falling edge. Controls are decoded combinationally from them, so they are
// stable by the next rising edge, where the datapath loads.
module microcode_sequencer #(
  parameter int OP_W     = 4,
  parameter int RING_LEN = 6,
  parameter int VAR_LEN  = 0
) (
  input  logic                clk,
  input  logic                low_res,
  input  logic [OP_W-1:0]     op_code,
  input  logic                zero_flag,
  input  logic                run,
  input  logic                step,
  output logic                inc,
  output logic                pc_out_en,
  output logic                low_ld_pc,
  output logic                low_ld_mar,
  output logic                low_mem_out_en,
  output logic                low_ld_ir,
  output logic                low_ir_out_en,
  output logic                low_ld_acc,
  output logic                acc_out_en,
  output logic                sub_add,
  output logic                subadd_out_en,
  output logic                low_ld_b_reg,
  output logic                low_ld_out_reg,
  output logic [RING_LEN-1:0] t_state,
  output logic                halted,
  output logic                instr_done
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [RING_LEN-1:0] T1_OH = {{(RING_LEN-1){1'b0}}, 1'b1};

  logic [RING_LEN-1:0] t_q, t_nxt, last_oh;
  logic                halted_q, halt_nxt;
  logic                op_hi;
  logic                is_lda, is_add, is_sub, is_jmp, is_jz, is_out, is_hlt;
  logic [2:0]          last_idx;
  logic                at_last, adv, live;

  // A nonzero bit above the 4-bit opcode field turns the instruction into a NOP.
  generate
    if (OP_W > 4) begin : g_op_hi
      assign op_hi = |op_code[OP_W-1:4];
    end else begin : g_no_op_hi
      assign op_hi = 1'b0;
    end
  endgenerate

  // Decode the live opcode. Only T4 onward uses it, after the IR has loaded.
  always_comb begin
    is_lda = 1'b0; is_add = 1'b0; is_sub = 1'b0; is_jmp = 1'b0;
    is_jz  = 1'b0; is_out = 1'b0; is_hlt = 1'b0;
    if (!op_hi) begin
      case (op_code[3:0])
        OP_LDA:  is_lda = 1'b1;
        OP_ADD:  is_add = 1'b1;
        OP_SUB:  is_sub = 1'b1;
        OP_JMP:  is_jmp = 1'b1;
        OP_JZ:   is_jz  = 1'b1;
        OP_OUT:  is_out = 1'b1;
        OP_HLT:  is_hlt = 1'b1;
        default: ;
      endcase
    end
  end

  // Last T-state index: per opcode in variable-length mode, else ring end.
  always_comb begin
    last_idx = 3'd2;
    if (is_lda)                            last_idx = 3'd4;
    if (is_add || is_sub)                  last_idx = 3'd5;
    if (is_jmp || is_jz || is_out || is_hlt) last_idx = 3'd3;
    last_oh = '0;
    if (VAR_LEN != 0) last_oh[last_idx]     = 1'b1;
    else              last_oh[RING_LEN-1]   = 1'b1;
  end

  assign at_last = |(t_q & last_oh);
  assign adv     = !halted_q && (run || step);
  assign live    = low_res && !halted_q;

  // State register: ring and sticky halt, falling edge, async reset.
  always_ff @(negedge clk or negedge low_res) begin
    if (!low_res) begin
      t_q      <= T1_OH;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_nxt;
      halted_q <= halt_nxt;
    end
  end

  // Next state: HLT in T4 freezes the ring; otherwise wrap or shift.
  always_comb begin
    t_nxt    = t_q;
    halt_nxt = halted_q;
    if (adv) begin
      if (is_hlt && t_q[3]) halt_nxt = 1'b1;
      else if (at_last)     t_nxt    = T1_OH;
      else                  t_nxt    = {t_q[RING_LEN-2:0], 1'b0};
    end
  end

  // Control decode. Everything is held inactive while in reset or halted.
  always_comb begin
    inc = 1'b0; pc_out_en = 1'b0; acc_out_en = 1'b0; sub_add = 1'b0;
    subadd_out_en = 1'b0;
    low_ld_pc = 1'b1; low_ld_mar = 1'b1; low_mem_out_en = 1'b1;
    low_ld_ir = 1'b1; low_ir_out_en = 1'b1; low_ld_acc = 1'b1;
    low_ld_b_reg = 1'b1; low_ld_out_reg = 1'b1;
    instr_done = 1'b0;
    if (live) begin
      instr_done = at_last;
      if (t_q[0]) begin
        pc_out_en  = 1'b1;
        low_ld_mar = 1'b0;
      end
      if (t_q[1]) inc = 1'b1;
      if (t_q[2]) begin
        low_mem_out_en = 1'b0;
        low_ld_ir      = 1'b0;
      end
      if (t_q[3]) begin
        if (is_lda || is_add || is_sub) begin
          low_ir_out_en = 1'b0;
          low_ld_mar    = 1'b0;
        end
        if (is_jmp) begin
          low_ir_out_en = 1'b0;
          low_ld_pc     = 1'b0;
        end
        if (is_jz) begin
          low_ir_out_en = 1'b0;
          low_ld_pc     = ~zero_flag;
        end
        if (is_out) begin
          acc_out_en     = 1'b1;
          low_ld_out_reg = 1'b0;
        end
      end
      if (t_q[4]) begin
        if (is_lda) begin
          low_mem_out_en = 1'b0;
          low_ld_acc     = 1'b0;
        end
        if (is_add || is_sub) begin
          low_mem_out_en = 1'b0;
          low_ld_b_reg   = 1'b0;
        end
      end
      if (t_q[5] && (is_add || is_sub)) begin
        subadd_out_en = 1'b1;
        low_ld_acc    = 1'b0;
        sub_add       = is_sub;
      end
    end
  end

  assign t_state = t_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer.
// dut0: fixed-length ring of 6 with a 4-bit opcode.
// dut1: variable-length with a 5-bit opcode, so the upper-bit NOP is covered.
// Stimulus pushes one expected record per cycle. The monitor pops a record
// and compares it on each rising edge.
module tb_microcode_sequencer;

  // Control vector order:
  // {inc, pc_out_en, low_ld_pc, low_ld_mar, low_mem_out_en, low_ld_ir,
  //  low_ir_out_en, low_ld_acc, acc_out_en, sub_add, subadd_out_en,
  //  low_ld_b_reg, low_ld_out_reg}
  localparam logic [12:0] IDLE   = 13'h07E3;
  localparam logic [12:0] M_INC  = 13'h1000, M_PCO  = 13'h0800, M_LPC  = 13'h0400;
  localparam logic [12:0] M_LMAR = 13'h0200, M_LMEM = 13'h0100, M_LIR  = 13'h0080;
  localparam logic [12:0] M_LIRO = 13'h0040, M_LACC = 13'h0020, M_ACCO = 13'h0010;
  localparam logic [12:0] M_SUB  = 13'h0008, M_SADD = 13'h0004, M_LB   = 13'h0002;
  localparam logic [12:0] M_LOUT = 13'h0001;

  localparam logic [12:0] F1     = IDLE ^ M_PCO ^ M_LMAR;
  localparam logic [12:0] F2     = IDLE ^ M_INC;
  localparam logic [12:0] F3     = IDLE ^ M_LMEM ^ M_LIR;
  localparam logic [12:0] C_LDA4 = IDLE ^ M_LIRO ^ M_LMAR;
  localparam logic [12:0] C_LDA5 = IDLE ^ M_LMEM ^ M_LACC;
  localparam logic [12:0] C_ADD5 = IDLE ^ M_LMEM ^ M_LB;
  localparam logic [12:0] C_ADD6 = IDLE ^ M_SADD ^ M_LACC;
  localparam logic [12:0] C_SUB6 = IDLE ^ M_SADD ^ M_LACC ^ M_SUB;
  localparam logic [12:0] C_JZN  = IDLE ^ M_LIRO;
  localparam logic [12:0] C_JMP  = IDLE ^ M_LIRO ^ M_LPC;
  localparam logic [12:0] C_OUT4 = IDLE ^ M_ACCO ^ M_LOUT;

  logic       clk = 1'b0, low_res = 1'b1, zero_flag = 1'b0, run = 1'b0, step = 1'b0;
  logic [4:0] op_code = 5'd0;
  wire [12:0] c0, c1;
  wire [5:0]  t0, t1;
  wire        h0, h1, d0, d1;

  typedef struct {
    string       tag;
    bit          sel;
    logic [5:0]  t;
    logic        h;
    logic        d;
    logic [12:0] c;
  } exp_t;

  exp_t q[$];
  int   errs = 0, checks = 0;

  always #5 clk = ~clk;

  microcode_sequencer #(.OP_W(4), .RING_LEN(6), .VAR_LEN(0)) dut0 (
    .clk(clk), .low_res(low_res), .op_code(op_code[3:0]), .zero_flag(zero_flag),
    .run(run), .step(step),
    .inc(c0[12]), .pc_out_en(c0[11]), .low_ld_pc(c0[10]), .low_ld_mar(c0[9]),
    .low_mem_out_en(c0[8]), .low_ld_ir(c0[7]), .low_ir_out_en(c0[6]),
    .low_ld_acc(c0[5]), .acc_out_en(c0[4]), .sub_add(c0[3]),
    .subadd_out_en(c0[2]), .low_ld_b_reg(c0[1]), .low_ld_out_reg(c0[0]),
    .t_state(t0), .halted(h0), .instr_done(d0));

  microcode_sequencer #(.OP_W(5), .RING_LEN(6), .VAR_LEN(1)) dut1 (
    .clk(clk), .low_res(low_res), .op_code(op_code), .zero_flag(zero_flag),
    .run(run), .step(step),
    .inc(c1[12]), .pc_out_en(c1[11]), .low_ld_pc(c1[10]), .low_ld_mar(c1[9]),
    .low_mem_out_en(c1[8]), .low_ld_ir(c1[7]), .low_ir_out_en(c1[6]),
    .low_ld_acc(c1[5]), .acc_out_en(c1[4]), .sub_add(c1[3]),
    .subadd_out_en(c1[2]), .low_ld_b_reg(c1[1]), .low_ld_out_reg(c1[0]),
    .t_state(t1), .halted(h1), .instr_done(d1));

  task automatic cmp(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Monitor: on every rising edge with a pending record, pop it and compare.
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        cmp({r.tag, " t_state"},    r.sel ? t1 : t0, r.t);
        cmp({r.tag, " halted"},     r.sel ? h1 : h0, r.h);
        cmp({r.tag, " instr_done"}, r.sel ? d1 : d0, r.d);
        cmp({r.tag, " controls"},   r.sel ? c1 : c0, r.c);
      end
    end
  end

  task automatic push(input string tag, input bit sel, input logic [5:0] t,
                      input logic h, input logic d, input logic [12:0] c);
    exp_t r;
    r.tag = tag; r.sel = sel; r.t = t; r.h = h; r.d = d; r.c = c;
    q.push_back(r);
  endtask

  // Expect this state at the coming rising edge, then move past the next
  // falling edge.
  task automatic chk(input string tag, input bit sel, input logic [5:0] t,
                     input logic h, input logic d, input logic [12:0] c);
    push(tag, sel, t, h, d, c);
    @(negedge clk); #1;
  endtask

  // Reset pulse of 15 ns that begins just after a falling edge. Two checks
  // fall inside the pulse; the first precedes any falling edge, so only an
  // asynchronous reset satisfies it.
  task automatic do_reset(input bit sel);
    @(negedge clk); #1;
    low_res = 1'b0;
    push("reset early", sel, 6'b000001, 1'b0, 1'b0, IDLE);
    #5;
    push("reset late", sel, 6'b000001, 1'b0, 1'b0, IDLE);
    #10;
    low_res = 1'b1;
    @(negedge clk); #1;
  endtask

  // One instruction starting in T1. The opcode is junk during T1/T2, which
  // must not matter. dn is the T-index where instr_done is expected (-1 none).
  task automatic instr(input string nm, input bit sel, input logic [4:0] op,
                       input logic zf, input int n, input int dn,
                       input logic [12:0] c4, input logic [12:0] c5,
                       input logic [12:0] c6);
    logic [12:0] cv [6];
    cv = '{F1, F2, F3, c4, c5, c6};
    zero_flag = zf;
    for (int i = 0; i < n; i++) begin
      op_code = (i < 2) ? ~op : op;
      chk($sformatf("%s T%0d", nm, i + 1), sel, 6'(1 << i), 1'b0, (i == dn), cv[i]);
    end
  endtask

  initial begin
    // Fixed-length machine, free run
    do_reset(1'b0);
    run = 1'b1;
    instr("LDA", 0, 5'h00, 0, 6, 5, C_LDA4, C_LDA5, IDLE);
    instr("SUB", 0, 5'h02, 0, 6, 5, C_LDA4, C_ADD5, C_SUB6);
    instr("ADD", 0, 5'h01, 0, 6, 5, C_LDA4, C_ADD5, C_ADD6);
    instr("JZ0", 0, 5'h04, 0, 6, 5, C_JZN,  IDLE,   IDLE);
    instr("JZ1", 0, 5'h04, 1, 6, 5, C_JMP,  IDLE,   IDLE);
    instr("JMP", 0, 5'h03, 0, 6, 5, C_JMP,  IDLE,   IDLE);
    instr("OUT", 0, 5'h0E, 0, 6, 5, C_OUT4, IDLE,   IDLE);
    instr("NOP", 0, 5'h07, 0, 6, 5, IDLE,   IDLE,   IDLE);
    zero_flag = 1'b0;

    // Sticky halt: ring frozen at T4, controls idle, run/step/op ignored
    instr("HLT", 0, 5'h0F, 0, 4, -1, IDLE, IDLE, IDLE);
    op_code = 5'h01;
    run = 1'b0; step = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 11) begin run = 1'b1; step = 1'b0; end
      chk("HLT hold", 0, 6'b001000, 1'b1, 1'b0, IDLE);
    end
    run = 1'b0; step = 1'b0;
    do_reset(1'b0);

    // Single-step mode: three one-cycle pulses with 5-cycle gaps
    op_code = 5'h00;
    for (int i = 0; i < 5; i++) chk("STEP hold T1", 0, 6'b000001, 1'b0, 1'b0, F1);
    step = 1'b1; chk("STEP pulse T1", 0, 6'b000001, 1'b0, 1'b0, F1); step = 1'b0;
    for (int i = 0; i < 5; i++) chk("STEP hold T2", 0, 6'b000010, 1'b0, 1'b0, F2);
    step = 1'b1; chk("STEP pulse T2", 0, 6'b000010, 1'b0, 1'b0, F2); step = 1'b0;
    for (int i = 0; i < 5; i++) chk("STEP hold T3", 0, 6'b000100, 1'b0, 1'b0, F3);
    step = 1'b1; chk("STEP pulse T3", 0, 6'b000100, 1'b0, 1'b0, F3); step = 1'b0;
    for (int i = 0; i < 5; i++) chk("STEP hold T4", 0, 6'b001000, 1'b0, 1'b0, C_LDA4);
    // step held high advances one state per cycle
    step = 1'b1;
    chk("STEP held T4", 0, 6'b001000, 1'b0, 1'b0, C_LDA4);
    chk("STEP held T5", 0, 6'b010000, 1'b0, 1'b0, C_LDA5);
    chk("STEP held T6", 0, 6'b100000, 1'b0, 1'b1, IDLE);
    chk("STEP held T1", 0, 6'b000001, 1'b0, 1'b0, F1);
    chk("STEP held T2", 0, 6'b000010, 1'b0, 1'b0, F2);
    step = 1'b0;
    chk("STEP park T3", 0, 6'b000100, 1'b0, 1'b0, F3);
    chk("STEP park T3", 0, 6'b000100, 1'b0, 1'b0, F3);
    do_reset(1'b0);
    chk("STEP after reset", 0, 6'b000001, 1'b0, 1'b0, F1);

    // Variable-length machine: OUT 4, LDA 5, ADD 6, upper-bit NOP 3
    do_reset(1'b1);
    run = 1'b1;
    instr("V OUT", 1, 5'h0E, 0, 4, 3, C_OUT4, IDLE,   IDLE);
    instr("V LDA", 1, 5'h00, 0, 5, 4, C_LDA4, C_LDA5, IDLE);
    instr("V ADD", 1, 5'h01, 0, 6, 5, C_LDA4, C_ADD5, C_ADD6);
    instr("V NOP", 1, 5'h10, 0, 3, 2, IDLE,   IDLE,   IDLE);
    chk("V wrap", 1, 6'b000001, 1'b0, 1'b0, F1);

    if (q.size() != 0) begin
      checks++; errs++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised successor to the SAP-1 control sequencer. It decodes the instruction-register opcode against a one-hot T-state ring counter and drives the active-high and active-low datapath control lines for the PC, MAR, RAM, IR, accumulator, adder/subtractor, B register and output register. Beyond the fixed six-state LDA/ADD/SUB/OUT/HLT machine, it adds:
- jump instructions;
- a sticky halt;
- a single-step mode;
- optional variable-length instructions.

## Interface
Parameters:
- OP_W, 4, opcode width; opcode compared on low 4 bits, any nonzero bit above bit 3 decodes as NOP
- RING_LEN, 6, T-states per fixed-length instruction; legal 6..8; states T7/T8 are NOP states
- VAR_LEN, 0, 1 = return to T1 after the last active T-state of each instruction

Ports:
- clk  in  1  single clock; ring counter and halt flag update on falling edge
- low_res  in  1  asynchronous active-low reset
- op_code  in  OP_W  IR opcode field
- zero_flag  in  1  accumulator == 0, from datapath
- run  in  1  1 = free-run, 0 = single-step
- step  in  1  single-step advance request, sampled on falling edge
- inc  out  1  PC increment
- pc_out_en  out  1  PC drives bus
- low_ld_pc  out  1  PC load from bus (jump), active-low
- low_ld_mar  out  1  MAR load, active-low
- low_mem_out_en  out  1  RAM drives bus, active-low
- low_ld_ir  out  1  IR load, active-low
- low_ir_out_en  out  1  IR operand drives bus, active-low
- low_ld_acc  out  1  accumulator load, active-low
- acc_out_en  out  1  accumulator drives bus
- sub_add  out  1  1 = subtract
- subadd_out_en  out  1  adder drives bus
- low_ld_b_reg  out  1  B load, active-low
- low_ld_out_reg  out  1  output register load, active-low
- t_state  out  RING_LEN  one-hot current T-state, bit 0 = T1
- halted  out  1  sticky halt indicator
- instr_done  out  1  high during the final T-state of an instruction

## Operation
- Opcodes: LDA 0000, ADD 0001, SUB 0010, JMP 0011, JZ 0100, OUT 1110, HLT 1111; all others NOP.
- Fetch, for all opcodes:
  - T1: pc_out_en=1, low_ld_mar=0
  - T2: inc=1
  - T3: low_mem_out_en=0, low_ld_ir=0
- LDA:
  - T4: low_ir_out_en=0, low_ld_mar=0
  - T5: low_mem_out_en=0, low_ld_acc=0
  - T6: idle
- ADD:
  - T4: as LDA T4
  - T5: low_mem_out_en=0, low_ld_b_reg=0
  - T6: subadd_out_en=1, low_ld_acc=0
- SUB: as ADD, plus sub_add=1 in T6 only.
- JMP:
  - T4: low_ir_out_en=0, low_ld_pc=0
- JZ:
  - T4: low_ir_out_en=0; low_ld_pc=0 only if zero_flag=1 (sampled combinationally during T4)
- OUT:
  - T4: acc_out_en=1, low_ld_out_reg=0
- HLT: entering T4 sets halted on the falling edge that ends T4.
  - Ring freezes at T4; all controls inactive from then on.
  - Only low_res clears halted.
- Any control not listed for a state is inactive: active-high lines 0, low_* lines 1.
- Last active state:
  - LDA = T5
  - ADD/SUB = T6
  - JMP/JZ/OUT = T4
  - NOP = T3
  - HLT = T4
- Instruction length:
  - VAR_LEN=0: every instruction runs RING_LEN states; instr_done=1 in T[RING_LEN].
  - VAR_LEN=1: ring returns to T1 after the last active state; instr_done=1 in that state.
- Advance condition: the ring advances on a falling edge when halted=0 and (run=1 or step=1).
  - In step mode, step held high advances one state per cycle.
  - run/step are ignored once halted.
- Reset: low_res=0 asynchronously forces t_state=T1, halted=0, instr_done=0 and all controls inactive (inc=0, pc_out_en=0, every low_* =1), including mid-instruction. Decoding resumes in T1 immediately after release.

## Timing
- Controls are combinational from registered t_state/halted and live op_code; they settle by the next rising edge, where the datapath loads.
- The IR loads on the rising edge in T3, so op_code is valid from T4.
- Ring length in clocks (VAR_LEN=0): RING_LEN per instruction.
- Ring length in clocks (VAR_LEN=1): LDA 5, ADD/SUB 6, JMP/JZ/OUT 4, NOP 3.
- Wrap-around: T[RING_LEN] or the last active state goes to T1, with no gap cycle.
- An op_code change during T1–T3 has no effect on outputs.
- Reset asserted on the same edge as a halt set: reset wins.

## Test plan
- Reset pulse low 15 ns, then LDA (0000), RING_LEN=6, run=1:
  - t_state 000001 → 000010 → … → 100000 → 000001
  - T1 pc_out_en=1/low_ld_mar=0; T5 low_mem_out_en=0/low_ld_acc=0
  - during reset every low_* =1
- SUB (0010):
  - T6: sub_add=1, subadd_out_en=1, low_ld_acc=0
  - T5: low_ld_b_reg=0, sub_add=0
- JZ (0100):
  - zero_flag=0: low_ld_pc stays 1 in T4
  - zero_flag=1: low_ld_pc=0 and low_ir_out_en=0 in T4
- HLT (1111):
  - halted rises after T4; t_state stays 001000 for 20+ cycles with all controls inactive
  - low_res pulse returns t_state to 000001, halted=0
- VAR_LEN=1, sequence OUT, LDA, ADD:
  - instr_done pulses after 4, then 5, then 6 clocks
  - t_state returns to T1 with no idle state
- run=0, step pulsed for one cycle three times with 5-cycle gaps:
  - t_state advances exactly T1→T2→T3→T4, holding between pulses
  - low_res asserted during T3 forces T1 asynchronously
